// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide sequencer: 32-step shift-add multiply and restoring
// divide, owning the architectural HI/LO pair and stalling issue while busy.
module muldiv_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        read_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;
  logic        op_div_q, op_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] mcand_q, mcand_d;
  logic [32:0] mplier_q, mplier_d;   // multiplier during MUL, divisor during DIV
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;

  logic        is_mul, is_div, signed_op, a_neg, b_neg;
  logic [32:0] abs_a, abs_b;
  logic [32:0] trial;
  logic [63:0] prod_fix;

  // Operand magnitudes are 33 bits wide so that |0x80000000| = 2^31 is exact.
  assign is_mul    = (funct_i == F_MULT) || (funct_i == F_MULTU);
  assign is_div    = (funct_i == F_DIV)  || (funct_i == F_DIVU);
  assign signed_op = (funct_i == F_MULT) || (funct_i == F_DIV);
  assign a_neg     = signed_op & rs_i[31];
  assign b_neg     = signed_op & rt_i[31];
  assign abs_a     = a_neg ? (33'd0 - {rs_i[31], rs_i}) : {1'b0, rs_i};
  assign abs_b     = b_neg ? (33'd0 - {rt_i[31], rt_i}) : {1'b0, rt_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = 1'b0;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    trial    = {rem_q, quo_q[31]};
    prod_fix = neg_q ? (64'd0 - prod_q) : prod_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            op_div_d = 1'b0;
            neg_d    = a_neg ^ b_neg;
            prod_d   = '0;
            mcand_d  = {31'd0, abs_a};
            mplier_d = abs_b;
          end else if (is_div) begin
            if (rt_i == 32'd0) begin
              lo_d = 32'hFFFF_FFFF;
              hi_d = rs_i;
              dz_d = 1'b1;
            end else begin
              state_d  = S_DIV;
              cnt_d    = '0;
              op_div_d = 1'b1;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              rem_d    = '0;
              quo_d    = abs_a[31:0];
              mplier_d = abs_b;
            end
          end else if (funct_i == F_MTHI) begin
            hi_d = rs_i;
          end else if (funct_i == F_MTLO) begin
            lo_d = rs_i;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        // Remainder is always below the divisor, so the low 32 bits of the
        // difference are exact.
        if (trial >= mplier_q) begin
          rem_d = trial[31:0] - mplier_q[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_div_q) begin
          lo_d = neg_q  ? (32'd0 - quo_q) : quo_q;
          hi_d = rneg_q ? (32'd0 - rem_q) : rem_q;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign stall_o    = busy_o & (start_i | read_i);
  assign rdata_o    = (funct_i == F_MFHI) ? hi_q :
                      (funct_i == F_MFLO) ? lo_q : 32'd0;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule
